// File: rtl/subleq_pkg.sv
// Shared types and default sizes for the Subleq memory host.
package subleq_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned MEM_DEPTH  = 2 ** DEF_ADDR_W;

    typedef enum logic [2:0] {
        StClear,
        StLoad,
        StRun,
        StDump,
        StDone
    } state_e;

endpackage

// File: rtl/subleq_ram.sv
// Word store: one synchronous write port, two combinational read ports
// (A for the core, B for the dump stream). Contents are never reset.
module subleq_ram
    import subleq_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/subleq_mem_host.sv
// Memory-side host for the Subleq core: clears the store, loads a program,
// runs the core until halt or cycle limit, then streams the memory out.
module subleq_mem_host
    import subleq_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned HALT_ADDR  = 1023,
    parameter int unsigned MAX_CYCLES = 100000,
    parameter int unsigned DUMP_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              writeEnable,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    output logic              core_reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    input  logic              restart,
    output logic              done,
    output logic              timeout
);

    localparam logic [ADDR_W-1:0] LastAddr = '1;
    localparam logic [ADDR_W-1:0] HaltAddr = ADDR_W'(HALT_ADDR);
    localparam logic [ADDR_W-1:0] LastDump = ADDR_W'(DUMP_WORDS - 1);
    localparam logic [31:0]       CycLimit = 32'(MAX_CYCLES - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic              core_reset_q, core_reset_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    subleq_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .raddr_a (addr),
        .rdata_a (readData),
        .raddr_b (ptr_q),
        .rdata_b (dump_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StClear;
            ptr_q        <= '0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            core_reset_q <= core_reset_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = '0;

        unique case (state_q)
            StClear: begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;  // wraps to 0 on the last address
                if (ptr_q == LastAddr) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (load_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = load_data;
                    ptr_d     = ptr_q + 1'b1;
                    if (load_last || ptr_q == LastAddr) begin
                        state_d = StRun;
                        ptr_d   = '0;
                    end
                end
            end
            StRun: begin
                mem_we    = writeEnable;
                mem_waddr = addr;
                mem_wdata = writeData;
                cnt_d     = cnt_q + 32'd1;
                // A halting write beats a simultaneous limit hit.
                if (writeEnable && addr == HaltAddr) begin
                    state_d   = StDump;
                    timeout_d = 1'b0;
                end else if (MAX_CYCLES != 0 && cnt_q == CycLimit) begin
                    state_d   = StDump;
                    timeout_d = 1'b1;
                end
            end
            StDump: begin
                if (dump_ready) begin
                    ptr_d = ptr_q + 1'b1;
                    if (dump_last) begin
                        state_d = StDone;
                        ptr_d   = '0;
                    end
                end
            end
            StDone: begin
                if (restart) begin
                    state_d   = StClear;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = StClear;
        endcase

        // Core stays in reset for the first RUN cycle and again from the first DUMP cycle.
        core_reset_d = !(state_q == StRun && state_d == StRun);
    end

    always_comb begin
        load_ready = (state_q == StLoad);
        dump_valid = (state_q == StDump);
        done       = (state_q == StDone);
    end

    assign dump_addr  = ptr_q;
    assign dump_last  = (ptr_q == LastDump);
    assign timeout    = timeout_q;
    assign core_reset = core_reset_q;

endmodule

// File: tb/tb_subleq_mem_host.sv
// Directed bench for subleq_mem_host with a small cycle limit so timeout runs stay short.
module tb_subleq_mem_host;

    localparam int unsigned AW   = 10;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXC = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] addr;
    logic          writeEnable;
    logic [DW-1:0] writeData;
    logic [DW-1:0] readData;
    logic          core_reset;
    logic          load_valid;
    logic          load_ready;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          dump_valid;
    logic          dump_ready;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_data;
    logic          dump_last;
    logic          restart;
    logic          done;
    logic          timeout;

    always #5 clk = ~clk;

    subleq_mem_host #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .HALT_ADDR  (1023),
        .MAX_CYCLES (MAXC),
        .DUMP_WORDS (1024)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .writeEnable (writeEnable),
        .writeData   (writeData),
        .readData    (readData),
        .core_reset  (core_reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_last   (load_last),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_addr   (dump_addr),
        .dump_data   (dump_data),
        .dump_last   (dump_last),
        .restart     (restart),
        .done        (done),
        .timeout     (timeout)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] exp;
    } rd_vec_t;

    rd_vec_t       rd_load [5];
    rd_vec_t       rd_wipe [4];
    logic [DW-1:0] model   [1024];
    logic [DW-1:0] cap     [1024];
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) model[i] = '0;
    endtask

    task automatic count_clear(input string name);
        int n;
        n = 0;
        while (load_ready !== 1'b1 && n < 5000) begin
            step();
            n++;
        end
        check(name, n, 1024);
    endtask

    task automatic load_word(input logic [DW-1:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic run_dump(input bit bp, input string tag);
        int            cyc, got, order_err, data_err, last_err, hold_err;
        logic [AW-1:0] exp_a, prev_a;
        logic [DW-1:0] prev_d;
        bit            prev_rdy;
        cyc = 0; got = 0; order_err = 0; data_err = 0; last_err = 0; hold_err = 0;
        exp_a = '0; prev_a = '0; prev_d = '0; prev_rdy = 1'b1;
        while (got < 1024 && cyc < 8000) begin
            dump_ready = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            if (dump_valid !== 1'b1 || dump_addr !== exp_a) order_err++;
            if (dump_data !== model[exp_a]) data_err++;
            if (dump_last !== (exp_a == 10'd1023)) last_err++;
            if (!prev_rdy && (dump_addr !== prev_a || dump_data !== prev_d)) hold_err++;
            prev_rdy = dump_ready;
            prev_a   = dump_addr;
            prev_d   = dump_data;
            if (dump_ready) begin
                cap[exp_a] = dump_data;
                exp_a++;
                got++;
            end
            step();
            cyc++;
        end
        dump_ready = 1'b0;
        check({tag, "_words"}, got, 1024);
        check({tag, "_cycles"}, cyc, bp ? 2048 : 1024);
        check({tag, "_order_errs"}, order_err, 0);
        check({tag, "_data_errs"}, data_err, 0);
        check({tag, "_last_errs"}, last_err, 0);
        check({tag, "_hold_errs"}, hold_err, 0);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_valid_low"}, dump_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rd_load[0] = '{a: 10'd0,    exp: 32'd5};
        rd_load[1] = '{a: 10'd1,    exp: 32'd6};
        rd_load[2] = '{a: 10'd2,    exp: 32'hFFFF_FFFF};
        rd_load[3] = '{a: 10'd3,    exp: 32'd0};
        rd_load[4] = '{a: 10'd1023, exp: 32'd0};
        rd_wipe[0] = '{a: 10'd0,    exp: 32'd0};
        rd_wipe[1] = '{a: 10'd1,    exp: 32'd0};
        rd_wipe[2] = '{a: 10'd100,  exp: 32'd0};
        rd_wipe[3] = '{a: 10'd1023, exp: 32'd0};

        reset = 1'b0; addr = '0; writeEnable = 1'b0; writeData = '0;
        load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        dump_ready = 1'b0; restart = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_core_reset", core_reset, 1'b1);
        check("rst_load_ready", load_ready, 1'b0);
        check("rst_dump_valid", dump_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_dump_addr", dump_addr, 0);
        reset = 1'b1;

        // Test 1: clear then 3-word image
        count_clear("clear_cycles_1");
        model_clear();
        model[0] = 32'd5; model[1] = 32'd6; model[2] = 32'hFFFF_FFFF;
        load_word(32'd5, 1'b0);
        load_word(32'd6, 1'b0);
        load_word(32'hFFFF_FFFF, 1'b1);
        check("run_first_core_reset", core_reset, 1'b1);
        check("run_load_ready", load_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            addr = rd_load[i].a;
            #1;
            check($sformatf("load_rd_%0d", rd_load[i].a), readData, rd_load[i].exp);
        end
        step();
        check("core_reset_fell", core_reset, 1'b0);

        // Test 2: scripted core writes then halt
        writeEnable = 1'b1; addr = 10'd7; writeData = 32'd42; model[7] = 32'd42;
        step();
        addr = 10'd1023; writeData = 32'd1; model[1023] = 32'd1;
        step();
        writeEnable = 1'b0; addr = '0;
        check("halt_dump_valid", dump_valid, 1'b1);
        check("halt_core_reset", core_reset, 1'b1);
        run_dump(1'b0, "dump1");
        check("dump1_addr7", cap[7], 32'd42);
        check("dump1_addr1023", cap[1023], 32'd1);
        check("dump1_timeout", timeout, 1'b0);

        // Test 6a: restart from DONE
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart_done_low", done, 1'b0);
        check("restart_in_clear", load_ready, 1'b0);
        count_clear("clear_cycles_2");

        // Test 6b: restart and core writes ignored in LOAD
        restart = 1'b1; writeEnable = 1'b1; addr = 10'd9; writeData = 32'hDEAD;
        repeat (3) step();
        restart = 1'b0; writeEnable = 1'b0;
        check("load_restart_ignored", load_ready, 1'b1);
        check("load_core_reset", core_reset, 1'b1);
        #1;
        check("load_we_ignored", readData, 32'd0);

        // Test 3: cycle limit
        model_clear();
        model[0] = 32'h11; model[1] = 32'h22; model[2] = 32'h33; model[3] = 32'h44;
        load_word(32'h11, 1'b0);
        load_word(32'h22, 1'b0);
        load_word(32'h33, 1'b0);
        load_word(32'h44, 1'b1);
        step();
        k = 1;
        check("limit_core_reset_low", core_reset, 1'b0);
        while (core_reset !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        check("limit_run_cycles", k, MAXC);
        check("limit_timeout", timeout, 1'b1);
        check("limit_dump_valid", dump_valid, 1'b1);

        // Test 4: dump under backpressure
        run_dump(1'b1, "dump_bp");
        check("done_timeout_held", timeout, 1'b1);

        // Test 5: async reset mid-run
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart_timeout_cleared", timeout, 1'b0);
        count_clear("clear_cycles_3");
        load_word(32'd7, 1'b0);
        load_word(32'd8, 1'b1);
        writeEnable = 1'b1; addr = 10'd100; writeData = 32'h55;
        step();
        writeEnable = 1'b0;
        repeat (9) step();
        #1;
        check("pre_reset_rd100", readData, 32'h55);
        check("pre_reset_core_reset", core_reset, 1'b0);
        reset = 1'b0;
        #1;
        check("async_core_reset", core_reset, 1'b1);
        check("async_load_ready", load_ready, 1'b0);
        check("async_dump_addr", dump_addr, 0);
        step();
        reset = 1'b1;
        count_clear("clear_cycles_4");
        for (int i = 0; i < 4; i++) begin
            addr = rd_wipe[i].a;
            #1;
            check($sformatf("wipe_rd_%0d", rd_wipe[i].a), readData, rd_wipe[i].exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/subleq_mem_host.md
Name: subleq_mem_host

Overview:
Memory-side responder for the Subleq core. It owns the 1024x32 word store the core reads and writes, and sequences one whole program run:
- clear memory;
- accept a program image over a valid/ready load stream;
- release the core from reset and serve its accesses;
- detect halt or timeout;
- stream the final memory image out over a valid/ready dump stream.

Parameters:
ADDR_W, 10, word address width (depth = 2**ADDR_W)
DATA_W, 32, word width
HALT_ADDR, 1023, a core write to this address halts the run
MAX_CYCLES, 100000, RUN-cycle limit before forced stop; 0 disables the limit
DUMP_WORDS, 1024, words streamed out in DUMP, from address 0

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 forces the reset state immediately
addr  in  ADDR_W  core word address
writeEnable  in  1  core write strobe
writeData  in  DATA_W  core write data
readData  out  DATA_W  mem[addr], combinational
core_reset  out  1  active-high reset to core; 0 only in RUN
load_valid  in  1  load word present
load_ready  out  1  block accepts load word
load_data  in  DATA_W  program word
load_last  in  1  final program word
dump_valid  out  1  dump word present
dump_ready  in  1  sink accepts dump word
dump_addr  out  ADDR_W  address of dump_data
dump_data  out  DATA_W  mem[dump_addr], combinational
dump_last  out  1  dump_addr == DUMP_WORDS-1
restart  in  1  in DONE: begin a new run
done  out  1  run finished, dump complete
timeout  out  1  last run ended by cycle limit

Behaviour:
- States: CLEAR, LOAD, RUN, DUMP, DONE.
- Reset (reset=0) values:
  - state=CLEAR; ptr=0; cycle counter=0.
  - core_reset=1; load_ready=0; dump_valid=0; done=0; timeout=0.
  - Memory contents are not reset; CLEAR overwrites them.
- CLEAR:
  - Writes 0 to mem[ptr], one word per cycle, ptr increments.
  - After writing address 2**ADDR_W-1: ptr=0, next state LOAD.
  - Takes exactly 1024 cycles at defaults.
- LOAD:
  - load_ready=1.
  - On each handshake (valid & ready): mem[ptr]=load_data, ptr++.
  - Handshake with load_last=1, or at ptr=2**ADDR_W-1 → RUN, ptr=0.
  - Words beyond the image remain 0.
- RUN:
  - core_reset is a registered output; it is 0 starting the cycle after RUN is entered.
  - Core write: mem[addr]=writeData on the rising edge while writeEnable=1.
  - The cycle counter increments each RUN cycle.
  - Halt: a write with addr==HALT_ADDR completes, then the next state is DUMP.
  - Limit: if MAX_CYCLES≠0 and counter==MAX_CYCLES-1 → DUMP, timeout=1.
  - Halt and limit in the same cycle: halt wins, timeout=0.
  - core_reset=1 from the first DUMP cycle.
- Outside RUN:
  - writeEnable is ignored.
  - readData still reflects mem[addr].
- DUMP:
  - dump_valid=1; dump_addr=ptr starting at 0.
  - ptr advances on handshake; dump_data is held stable while dump_ready=0.
  - Handshake with dump_last → DONE.
- DONE:
  - done=1; timeout holds its value.
  - restart=1 → CLEAR, done=0, timeout=0, counter=0.
  - restart is ignored in every other state.
- Write-port priority: only one source is active per state (CLEAR zero, LOAD stream, RUN core), so there are no collisions.
- Counter width is 32 bits; no wrap occurs while MAX_CYCLES < 2**32.
- Async reset mid-run (any state) → CLEAR with the reset values above; core_reset=1 asynchronously.

Decomposition:
- Shared package subleq_pkg holds:
  - the state enum (CLEAR, LOAD, RUN, DUMP, DONE);
  - ADDR_W / DATA_W default constants;
  - the memory depth constant.
- One sub-module, subleq_ram: one synchronous write port and two combinational read ports. Port A serves the core (readData); port B serves dump_data.
- subleq_mem_host holds the FSM, pointer, cycle counter and write mux.

Test Plan:
1. Reset, then a 3-word image {5,6,0xFFFFFFFF} with load_last on the 3rd word.
   → LOAD entered at cycle 1024. mem[0..2] match the image, mem[3]=0. core_reset falls 1 cycle after the last handshake.
2. Scripted core: write 42 to addr 7, then write 1 to HALT_ADDR=1023.
   → State becomes DUMP after the halt write. Dump stream carries addr 7=42 and 1023=1. timeout=0, done=1 after the 1024th handshake.
3. MAX_CYCLES=20, core never writes HALT_ADDR.
   → core_reset=1 after exactly 20 RUN cycles. timeout=1; dump matches the loaded image.
4. Dump backpressure: dump_ready toggled 1,0,0,1.
   → dump_addr/dump_data held during stalls. No word skipped or duplicated; dump_last only at addr 1023.
5. Assert reset=0 mid-RUN at cycle 10.
   → core_reset=1 immediately, state CLEAR. After release, 1024 clear cycles, then a fresh LOAD; old contents read as 0.
6. In DONE, pulse restart; in LOAD, drive restart=1.
   → From DONE: new CLEAR, done=0. In LOAD: restart is ignored.
